// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers
//
// Ports:
//   clk_i            system clock
//   rst_i            synchronous active-high reset
//   req_valid_i      per-requester byte-available flag
//   req_data_i       packed bytes, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_par_en_i     per-requester parity enable
//   req_par_typ_i    per-requester parity type (0 even, 1 odd)
//   req_ready_o      one-hot accept strobe (combinational, IDLE only)
//   tx_p_data_o      byte to transmitter, held from capture to next capture
//   tx_data_valid_o  one-cycle launch pulse
//   tx_par_en_o      parity enable to transmitter
//   tx_par_typ_o     parity type to transmitter
//   tx_busy_i        transmitter busy
//   grant_id_o       requester owning the current frame
//   arb_err_o        one-cycle pulse when BUSY never rises after a launch
//
// Optional: define UART_TX_ARB_GUARD_EN to insert GUARD_CYCLES idle cycles after each frame.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int START_TIMEOUT = 15,
    parameter int GUARD_CYCLES  = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_par_en_i,
    input  logic [NUM_REQ-1:0]            req_par_typ_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]         tx_p_data_o,
    output logic                          tx_data_valid_o,
    output logic                          tx_par_en_o,
    output logic                          tx_par_typ_o,
    input  logic                          tx_busy_i,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
    output logic                          arb_err_o
);
    localparam int IW      = $clog2(NUM_REQ);
    // One counter serves both the start timeout and the guard interval.
    localparam int CNT_MAX = (START_TIMEOUT > GUARD_CYCLES) ? START_TIMEOUT : GUARD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
`ifdef UART_TX_ARB_GUARD_EN
        , GUARD
`endif
    } state_t;

    state_t                state_q;
    logic [IW-1:0]         ptr_q;
    logic [IW-1:0]         grant_id_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] tx_p_data_q;
    logic                  tx_data_valid_q;
    logic                  tx_par_en_q;
    logic                  tx_par_typ_q;
    logic                  arb_err_q;
    logic [IW-1:0]         win;
    logic [IW-1:0]         idx;
    logic                  found;
    logic                  grant;
    logic [DATA_WIDTH-1:0] bytes [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) bytes[i] = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan starts one past the last winner so every requester is reached within NUM_REQ grants.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_valid_i[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign grant       = !rst_i && state_q == IDLE && !tx_busy_i && found;
    assign req_ready_o = grant ? NUM_REQ'(1) << win : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            ptr_q           <= IW'(NUM_REQ - 1);
            grant_id_q      <= '0;
            cnt_q           <= '0;
            tx_p_data_q     <= '0;
            tx_data_valid_q <= 1'b0;
            tx_par_en_q     <= 1'b0;
            tx_par_typ_q    <= 1'b0;
            arb_err_q       <= 1'b0;
        end else begin
            tx_data_valid_q <= 1'b0;
            arb_err_q       <= 1'b0;
            case (state_q)
                IDLE: if (grant) begin
                    tx_p_data_q     <= bytes[win];
                    tx_par_en_q     <= req_par_en_i[win];
                    tx_par_typ_q    <= req_par_typ_i[win];
                    grant_id_q      <= win;
                    ptr_q           <= win;
                    tx_data_valid_q <= 1'b1;
                    state_q         <= LAUNCH;
                end
                LAUNCH: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: if (tx_busy_i) begin
                    state_q <= WAIT_DONE;
                end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
                    arb_err_q <= 1'b1;
                    state_q   <= IDLE;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
`ifdef UART_TX_ARB_GUARD_EN
                WAIT_DONE: if (!tx_busy_i) begin
                    cnt_q   <= '0;
                    state_q <= GUARD;
                end
                GUARD: if (cnt_q == CW'(GUARD_CYCLES - 1)) state_q <= IDLE;
                else cnt_q <= cnt_q + CW'(1);
`else
                WAIT_DONE: if (!tx_busy_i) state_q <= IDLE;
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_p_data_o     = tx_p_data_q;
    assign tx_data_valid_o = tx_data_valid_q;
    assign tx_par_en_o     = tx_par_en_q;
    assign tx_par_typ_o    = tx_par_typ_q;
    assign grant_id_o      = grant_id_q;
    assign arb_err_o       = arb_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with a round-robin reference model
module tb_uart_tx_arbiter;
    localparam int NUM_REQ       = 4;
    localparam int START_TIMEOUT = 15;
    localparam int GUARD_CYCLES  = 2;
    localparam int BUSY_LEN      = 11;
`ifdef UART_TX_ARB_GUARD_EN
    localparam int GAP = GUARD_CYCLES + 1;
`else
    localparam int GAP = 1;
`endif

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       pt;
        int         id;
        int         c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_par_en = '0;
    logic [3:0]  req_par_typ = '0;
    logic [3:0]  req_ready;
    logic [7:0]  tx_p_data;
    logic        tx_data_valid;
    logic        tx_par_en;
    logic        tx_par_typ;
    logic [1:0]  grant_id;
    logic        arb_err;
    logic        busy_m = 1'b0;
    logic        busy_force = 1'b0;
    logic        busy_on = 1'b1;
    logic        tx_busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   launch_log[$];
    int   launch_cyc_log[$];
    int   hs_gap[$];
    int   err_log[$];
    int   cyc = 0;
    int   fall_cyc = 0;
    int   ptr_m = NUM_REQ - 1;
    logic prev_busy = 1'b0;
    logic prev_valid = 1'b0;
    exp_t e;
    int   w;
    int   bm_left = 0;
    bit   bm_pend = 1'b0;

    assign tx_busy = busy_m | busy_force;

    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_par_en_i   (req_par_en),
        .req_par_typ_i  (req_par_typ),
        .req_ready_o    (req_ready),
        .tx_p_data_o    (tx_p_data),
        .tx_data_valid_o(tx_data_valid),
        .tx_par_en_o    (tx_par_en),
        .tx_par_typ_o   (tx_par_typ),
        .tx_busy_i      (tx_busy),
        .grant_id_o     (grant_id),
        .arb_err_o      (arb_err)
    );

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_launches(int n, int lim);
        int t = 0;
        while (launch_log.size() < n && t < lim) begin
            tick(1);
            t++;
        end
        if (launch_log.size() < n) chk("wait_launch_bound", launch_log.size(), n);
    endtask

    // Reference arbitration: first valid requester after the last winner, wrapping.
    function automatic int rr_pick(int p, logic [3:0] v);
        for (int k = 1; k <= NUM_REQ; k++) if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        return -1;
    endfunction

    // Transmitter model: BUSY rises the cycle after a launch and stays high BUSY_LEN cycles.
    initial forever begin
        @(posedge clk);
        #2;
        if (rst) begin
            busy_m  = 1'b0;
            bm_left = 0;
            bm_pend = 1'b0;
        end else begin
            if (bm_left > 0) begin
                bm_left--;
                if (bm_left == 0) busy_m = 1'b0;
            end
            if (bm_pend) begin
                bm_pend = 1'b0;
                busy_m  = 1'b1;
                bm_left = BUSY_LEN;
            end
            if (tx_data_valid && busy_on) bm_pend = 1'b1;
        end
    end

    // Monitor: predicts on each handshake, checks on each launch.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            ptr_m = NUM_REQ - 1;
            sb.delete();
            chk("rst_ready", int'(req_ready), 0);
        end else begin
            if (prev_busy && !tx_busy) fall_cyc = cyc;
            if (req_ready != '0) begin
                w = rr_pick(ptr_m, req_valid);
                chk("ready_onehot", int'(req_ready), (w < 0) ? 0 : (1 << w));
                chk("ready_while_busy", int'(tx_busy), 0);
                if (w >= 0) begin
                    e.d  = req_data[w*8 +: 8];
                    e.pe = req_par_en[w];
                    e.pt = req_par_typ[w];
                    e.id = w;
                    e.c  = cyc + 1;
                    sb.push_back(e);
                    ptr_m = w;
                end
                hs_gap.push_back(cyc - fall_cyc);
            end
            if (tx_data_valid) begin
                if (sb.size() == 0) begin
                    chk("launch_unexpected", int'(tx_data_valid), 0);
                end else begin
                    e = sb.pop_front();
                    chk("launch_data", int'(tx_p_data), int'(e.d));
                    chk("launch_par", int'({tx_par_en, tx_par_typ}), int'({e.pe, e.pt}));
                    chk("launch_id", int'(grant_id), e.id);
                    chk("launch_latency", cyc, e.c);
                end
                chk("launch_single", int'(prev_valid), 0);
                launch_log.push_back(int'(tx_p_data));
                launch_cyc_log.push_back(cyc);
            end
            if (arb_err) err_log.push_back(cyc);
        end
        prev_busy  = tx_busy;
        prev_valid = tx_data_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int lb;
        int hb;
        int t;
        byte rr_exp [4];
        rr_exp = '{8'h10, 8'h21, 8'h32, 8'h43};

        tick(3);
        chk("rst_outputs", int'({req_ready, tx_p_data, tx_data_valid, tx_par_en, tx_par_typ, grant_id, arb_err}), 0);
        rst = 1'b0;

        // single request
        req_valid = 4'b0001; req_data = 32'h000000A5; req_par_en = 4'b0001; req_par_typ = 4'b0000;
        #1 chk("single_ready", int'(req_ready), 1);
        tick(1);
        req_valid = '0;
        chk("single_valid", int'(tx_data_valid), 1);
        chk("single_data", int'(tx_p_data), 'hA5);
        chk("single_par", int'({tx_par_en, tx_par_typ}), 2);
        chk("single_id", int'(grant_id), 0);
        tick(1);
        chk("single_pulse_end", int'(tx_data_valid), 0);
        tick(30);

        // round robin with all requesters valid
        rst = 1'b1; tick(2); rst = 1'b0;
        req_valid = 4'b1111; req_data = 32'h43322110; req_par_en = 4'b0101; req_par_typ = 4'b0011;
        lb = launch_log.size();
        hb = hs_gap.size();
        wait_launches(lb + 5, 200);
        req_valid = '0;
        for (int k = 0; k < 5; k++) chk("rr_order", launch_log[lb+k], int'(rr_exp[k%4]));
        for (int k = 1; k < 5; k++) begin
            chk("rr_spacing", launch_cyc_log[lb+k] - launch_cyc_log[lb+k-1], 13 + GAP);
            chk("rr_busy_to_ready", hs_gap[hb+k], GAP);
        end
        tick(30);

        // busy blocks grants in IDLE
        busy_force = 1'b1;
        req_valid = 4'b0100; req_data = 32'h005A0000;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("busy_block", int'(req_ready), 0);
        end
        busy_force = 1'b0;
        #1 chk("busy_release", int'(req_ready), 4'b0100);
        tick(1);
        req_valid = '0;
        chk("busy_launch_id", int'(grant_id), 2);
        tick(30);

        // start timeout, then next valid requester
        busy_on = 1'b0;
        req_valid = 4'b1000; req_data = 32'h99007700;
        tick(1);
        req_valid = 4'b0010;
        t = 0;
        while (!arb_err && t < 40) begin
            tick(1);
            t++;
        end
        chk("timeout_seen", int'(arb_err), 1);
        busy_on = 1'b1;
        tick(1);
        chk("timeout_pulse_end", int'(arb_err), 0);
        chk("timeout_latency", err_log[$] - launch_cyc_log[$], START_TIMEOUT + 1);
        tick(1);
        req_valid = '0;
        chk("after_timeout_data", launch_log[$], 'h77);
        chk("after_timeout_start", launch_cyc_log[$] - err_log[$], 1);
        tick(30);

        // reset during WAIT_DONE
        req_valid = 4'b0100; req_data = 32'h00C70000; req_par_en = 4'b0100; req_par_typ = 4'b0100;
        tick(1);
        req_valid = '0;
        chk("mid_launch", int'(tx_data_valid), 1);
        tick(6);
        chk("mid_data_held", int'(tx_p_data), 'hC7);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_outputs", int'({req_ready, tx_p_data, tx_data_valid, tx_par_en, tx_par_typ, grant_id, arb_err}), 0);
        tick(1);
        rst = 1'b0;
        req_valid = 4'b1111;
        #1 chk("post_rst_ready", int'(req_ready), 1);
        tick(1);
        req_valid = '0;
        chk("post_rst_id", int'(grant_id), 0);
        tick(30);

        // randomized traffic checked by the monitor
        lb = launch_log.size();
        repeat (800) begin
            req_valid   = 4'($urandom);
            req_data    = $urandom;
            req_par_en  = 4'($urandom);
            req_par_typ = 4'($urandom);
            tick(1);
        end
        req_valid = '0;
        tick(40);
        chk("rand_drain", sb.size(), 0);
        chk("rand_live", int'(launch_log.size() - lb >= 30), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter between NUM_REQ byte producers.
- Accepts one byte per valid/ready handshake, together with that requester's parity settings, and launches it with a one-cycle Data_Valid pulse.
- Tracks the transmitter's BUSY to sequence frames back-to-back without loss.
- Sits between the producer blocks and the TX top (FSM, serializer, parity calc, mux).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, byte width; matches the TX serializer.
- START_TIMEOUT, 15, maximum cycles to wait for BUSY to rise after launch (1..255).
- GUARD_CYCLES, 2, idle cycles inserted after each frame; used only with the optional feature.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  NUM_REQ  per-requester byte-available flag.
- REQ_DATA  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- REQ_PAR_EN  in  NUM_REQ  per-requester parity enable.
- REQ_PAR_TYP  in  NUM_REQ  per-requester parity type (0 even, 1 odd).
- REQ_READY  out  NUM_REQ  one-hot accept strobe.
- TX_P_DATA  out  DATA_WIDTH  byte to transmitter.
- TX_DATA_VALID  out  1  one-cycle launch pulse.
- TX_PAR_EN  out  1  parity enable to transmitter.
- TX_PAR_TYP  out  1  parity type to transmitter.
- TX_BUSY  in  1  transmitter busy.
- GRANT_ID  out  $clog2(NUM_REQ)  index of the requester owning the current frame.
- ARB_ERR  out  1  one-cycle pulse on start timeout.

Behaviour:
- Reset (RST=1 at a CLK edge): state IDLE; last-grant pointer = NUM_REQ-1, so requester 0 wins first. All outputs are 0, and REQ_READY is forced to 0 while RST=1.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, and GUARD (GUARD exists only with the optional feature).
- IDLE, grant condition: any REQ_VALID=1 and TX_BUSY=0.
  - The winner is the first requester with VALID=1, scanning from pointer+1 with wrap modulo NUM_REQ.
  - REQ_READY[winner]=1 combinationally in that same cycle; this is the handshake.
  - On that edge: capture the winner's byte, PAR_EN and PAR_TYP into the TX_* registers; set GRANT_ID=winner and pointer=winner; go to LAUNCH.
  - If TX_BUSY=1 in IDLE, no grant is made and REQ_READY stays 0.
- LAUNCH:
  - TX_DATA_VALID=1 for exactly one cycle. Accept-to-launch latency is 1 cycle.
  - Go to WAIT_BUSY.
  - The TX_* data and parity outputs are held stable from capture until the next capture.
- WAIT_BUSY:
  - A cycle counter starts at 0.
  - TX_BUSY=1 -> go to WAIT_DONE.
  - Counter reaches START_TIMEOUT with BUSY still 0 -> ARB_ERR=1 for one cycle, frame is dropped, go to IDLE.
- WAIT_DONE: TX_BUSY falls to 0 -> go to IDLE (or to GUARD with the optional feature).
- No new REQ_READY is issued outside IDLE. At most one handshake per frame.
- A requester deasserting VALID before it is granted is legal; it simply loses that arbitration.
- Back-to-back throughput: the next grant can occur in the first IDLE cycle after BUSY falls.
- Reset mid-frame (any state): return to IDLE with all outputs 0 on the next edge. The in-flight byte is abandoned; no ARB_ERR is raised.
- With NUM_REQ all valid continuously, grant order is 0,1,2,3,0,... and no requester waits more than NUM_REQ-1 frames.

Optional Feature:
- Macro UART_TX_ARB_GUARD_EN.
- Defined: WAIT_DONE goes to GUARD, which holds for GUARD_CYCLES cycles (counter 0..GUARD_CYCLES-1) with REQ_READY=0, then goes to IDLE. This guarantees at least GUARD_CYCLES+1 idle stop-level cycles between frames.
- Undefined: the GUARD state and its counter are absent; WAIT_DONE goes directly to IDLE.

Test Plan:
- Single request: after reset, REQ_VALID=4'b0001 with byte 0xA5, PAR_EN=1, PAR_TYP=0.
  - REQ_READY=4'b0001 in the same cycle.
  - Next cycle: TX_DATA_VALID=1, TX_P_DATA=0xA5, TX_PAR_EN=1, TX_PAR_TYP=0, GRANT_ID=0.
- Round robin: all four valid with bytes 0x10, 0x21, 0x32, 0x43; BUSY model high 11 cycles per frame.
  - Launch order is 0x10, 0x21, 0x32, 0x43, then 0x10.
  - Exactly one TX_DATA_VALID pulse per frame.
- Busy blocking: hold TX_BUSY=1 while in IDLE with REQ_VALID=4'b0100 -> REQ_READY stays 0. Release BUSY -> grant 2 in that cycle.
- Start timeout: BUSY never rises after launch -> ARB_ERR pulses exactly START_TIMEOUT=15 cycles into WAIT_BUSY. The arbiter returns to IDLE and grants the next valid requester.
- Reset mid-frame: assert RST during WAIT_DONE -> all outputs 0 on the next edge. After release, requester 0 wins first again.
- Guard (macro defined, GUARD_CYCLES=2): BUSY falls -> the next REQ_READY is no earlier than 3 cycles later. Without the macro, REQ_READY comes 1 cycle after BUSY falls.
